// File: rtl/wishbone2ram_lat_bridge_pkg.sv
// Shared types and constants for the Wishbone to latency-RAM bridge.
// FSM state encoding, RAM control levels and latency counter helpers.
package wishbone2ram_lat_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int LAT_CNT_W = 2;

    // Counter preload so the last WAIT cycle sees zero.
    function automatic logic [LAT_CNT_W-1:0] lat_init(
        input int lat
    );
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/wishbone2ram_lat_bridge_addr_window_check.sv
// Address window decoder: in-range flag and base-relative address.
// Ports: addr (byte address) -> in_range, offset (addr - BASE_ADDR).
module wb_addr_window_check #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES =
        ADDR_WIDTH'(32'h0002_0000)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  in_range,
    output logic [ADDR_WIDTH-1:0] offset
);

    // One extra bit keeps BASE+SIZE from wrapping.
    localparam logic [ADDR_WIDTH:0] LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] HI = LO + {1'b0, SIZE_BYTES};

    logic [ADDR_WIDTH:0] addr_x;

    assign addr_x   = {1'b0, addr};
    assign in_range = (addr_x >= LO) && (addr_x < HI);
    assign offset   = addr - BASE_ADDR;

endmodule

// File: rtl/wishbone2ram_lat_bridge.sv
// Wishbone classic slave to synchronous single-port RAM with read latency.
// Ports: wishbone_* slave side, ram_* registered RAM side, busy_o status.
module wishbone2ram_lat_bridge
    import wishbone2ram_lat_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int                    RD_LATENCY = 1,
    parameter int                    REG_RDATA  = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES =
        ADDR_WIDTH'(32'h0002_0000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wishbone_cyc_i,
    input  logic                  wishbone_stb_i,
    input  logic                  wishbone_we_i,
    input  logic [ADDR_WIDTH-1:0] wishbone_addr_i,
    input  logic [DATA_WIDTH-1:0] wishbone_data_i,
    input  logic [SEL_WIDTH-1:0]  wishbone_sel_i,
    output logic [DATA_WIDTH-1:0] wishbone_data_o,
    output logic                  wishbone_ack_o,
    output logic                  wishbone_err_o,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic [SEL_WIDTH-1:0]  ram_sel_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  busy_o
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("RD_LATENCY must be within 1..4");
    end

    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end

    if (SIZE_BYTES == '0) begin : g_bad_size
        $error("SIZE_BYTES must be greater than 0");
    end

    localparam bit REG = (REG_RDATA != 0);
    localparam logic [LAT_CNT_W-1:0] LAT0 =
        lat_init(RD_LATENCY);

    state_t                  state;
    state_t                  state_nx;
    logic                    ce_q;
    logic                    ce_nx;
    logic                    we_q;
    logic                    we_nx;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic [DATA_WIDTH-1:0]   wdat_q;
    logic [DATA_WIDTH-1:0]   wdat_nx;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic [SEL_WIDTH-1:0]    sel_nx;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   rdata_nx;
    logic [LAT_CNT_W-1:0]    lat_cnt;
    logic [LAT_CNT_W-1:0]    lat_nx;

    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    req;
    logic                    data_valid;

    wb_addr_window_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .SIZE_BYTES (SIZE_BYTES)
    ) u_window (
        .addr     (wishbone_addr_i),
        .in_range (in_range),
        .offset   (offset)
    );

    assign req        = wishbone_cyc_i && wishbone_stb_i;
    assign data_valid = (state == ST_WAIT) && (lat_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ce_q    <= CHIP_DISABLE;
            we_q    <= WRITE_DISABLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nx;
            ce_q    <= ce_nx;
            we_q    <= we_nx;
            addr_q  <= addr_nx;
            wdat_q  <= wdat_nx;
            sel_q   <= sel_nx;
            rdata_q <= rdata_nx;
            lat_cnt <= lat_nx;
        end
    end

    // cyc_i only gates ack/err; the walk back to IDLE never
    // shortens, so an issued RAM op always finishes cleanly.
    always_comb begin
        state_nx = state;
        ce_nx    = ce_q;
        we_nx    = we_q;
        addr_nx  = addr_q;
        wdat_nx  = wdat_q;
        sel_nx   = sel_q;
        rdata_nx = rdata_q;
        lat_nx   = lat_cnt;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    if (in_range) begin
                        state_nx = ST_ISSUE;
                        ce_nx    = CHIP_ENABLE;
                        we_nx    = wishbone_we_i;
                        addr_nx  = offset;
                        wdat_nx  = wishbone_data_i;
                        sel_nx   = wishbone_sel_i;
                    end else begin
                        state_nx = ST_ERR;
                    end
                end
            end
            ST_ISSUE: begin
                ce_nx = CHIP_DISABLE;
                we_nx = WRITE_DISABLE;
                if (we_q) begin
                    state_nx = ST_ACK;
                end else begin
                    lat_nx   = LAT0;
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    if (REG) begin
                        rdata_nx = ram_data_i;
                        state_nx = ST_ACK;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    lat_nx = lat_cnt - 1'b1;
                end
            end
            ST_ACK:  state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign wishbone_ack_o = wishbone_cyc_i &&
        ((state == ST_ACK) || (!REG && data_valid));
    assign wishbone_err_o  = wishbone_cyc_i && (state == ST_ERR);
    assign wishbone_data_o = REG ? rdata_q : ram_data_i;
    assign busy_o          = (state != ST_IDLE);

    assign ram_ce_o   = ce_q;
    assign ram_we_o   = we_q;
    assign ram_addr_o = addr_q;
    assign ram_data_o = wdat_q;
    assign ram_sel_o  = sel_q;

endmodule
